// File: rtl/board_io_hub.sv
// -----------------------------------------------------------------------------
// board_io_hub
//
// Front-panel controller behind one Avalon-MM slave. It gives register access
// to the LEDs, the 7-segment digits (through a hex decoder), the synchronised
// slide switches, the debounced push buttons with press capture, and a
// free-running counter.
//
// Word address map:
//   0 LED      RW  low NUM_LEDS bits
//   1 HEXVAL   RW  nibble i drives digit i
//   2 HEXBLANK RW  1 blanks digit i
//   3 SWSTAT   RO  synchronised switches
//   4 KEYSTAT  RO  debounced keys, 1 = pressed
//   5 KEYEDGE  RW1C, set on a debounced press
//   6 COUNT    RO  free-running counter
//   7 BRIGHT   RW  8-bit LED/HEX brightness when PWM_EN is defined, else reads 0
//
// Ports:
//   CLOCK_50           sole clock
//   reset              synchronous, active-high reset
//   avs_address        word address
//   avs_read/avs_write read and write strobes (no waitrequest)
//   avs_writedata      write data
//   avs_readdata       registered read data
//   avs_readdatavalid  high one cycle after an accepted read
//   LEDR               LED drive, 1 = on
//   HEX                digit i = HEX[7i+6:7i], active-low, bit order g..a
//   SW                 raw asynchronous switches
//   KEY                raw asynchronous buttons, 0 = pressed
//
// Build option: define PWM_EN to add the BRIGHT register and PWM gating of
// LEDR and HEX.
// -----------------------------------------------------------------------------
module board_io_hub #(
    parameter int NUM_LEDS        = 10,
    parameter int NUM_HEX         = 6,
    parameter int NUM_SW          = 10,
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COUNT_W         = 28
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic [NUM_LEDS-1:0]  LEDR,
    output logic [7*NUM_HEX-1:0] HEX,
    input  logic [NUM_SW-1:0]    SW,
    input  logic [NUM_KEYS-1:0]  KEY
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The toggle happens on the edge where the count would reach
    // DEBOUNCE_CYCLES, so a clean press lands 2 + DEBOUNCE_CYCLES cycles
    // after the pin moves.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        A_LED      = 3'd0,
        A_HEXVAL   = 3'd1,
        A_HEXBLANK = 3'd2,
        A_SWSTAT   = 3'd3,
        A_KEYSTAT  = 3'd4,
        A_KEYEDGE  = 3'd5,
        A_COUNT    = 3'd6,
        A_RSVD     = 3'd7
    } addr_e;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    addr_e addr;
    assign addr = addr_e'(avs_address);

    // Register file and panel state.
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic [4*NUM_HEX-1:0] hexval_q, hexval_d;
    logic [NUM_HEX-1:0]   hexblank_q, hexblank_d;
    logic [NUM_SW-1:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [NUM_KEYS-1:0]  key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [NUM_KEYS-1:0]  keystat_q, keystat_d;
    logic [NUM_KEYS-1:0]  keyedge_q, keyedge_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 readdatavalid_q, readdatavalid_d;
    logic [NUM_LEDS-1:0]  ledr_q, ledr_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;

    deb_state_e           deb_state_q [NUM_KEYS];
    deb_state_e           deb_state_d [NUM_KEYS];
    logic [CNT_W-1:0]     deb_cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]     deb_cnt_d   [NUM_KEYS];

    logic [NUM_KEYS-1:0]  key_pressed;
    logic [NUM_KEYS-1:0]  edge_clr;
    logic                 pwm_on;

`ifdef PWM_EN
    logic [7:0]           bright_q, bright_d;
    logic [7:0]           pwm_cnt_q, pwm_cnt_d;
    assign pwm_on = (pwm_cnt_q < bright_q);
`else
    assign pwm_on = 1'b1;
`endif

    // Write data bits above the widest field are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, avs_writedata};

    assign key_pressed = ~key_sync_q;

    // -------------------------------------------------------------------------
    // Per-key debouncer: STABLE waits for a mismatch, COUNTING requires the
    // mismatch to persist before KEYSTAT follows.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a variable unassigned and no latch is inferred.
        keystat_d = keystat_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            deb_state_d[k] = deb_state_q[k];
            deb_cnt_d[k]   = deb_cnt_q[k];
            case (deb_state_q[k])
                ST_STABLE: begin
                    if (key_pressed[k] != keystat_q[k]) begin
                        deb_state_d[k] = ST_COUNTING;
                        deb_cnt_d[k]   = CNT_ONE;
                    end
                end
                ST_COUNTING: begin
                    if (key_pressed[k] == keystat_q[k]) begin
                        deb_state_d[k] = ST_STABLE;
                        deb_cnt_d[k]   = '0;
                    end else if (deb_cnt_q[k] == DEB_LAST) begin
                        keystat_d[k]   = ~keystat_q[k];
                        deb_state_d[k] = ST_STABLE;
                        deb_cnt_d[k]   = '0;
                    end else begin
                        deb_cnt_d[k]   = deb_cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    deb_state_d[k] = ST_STABLE;
                    deb_cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus writes, synchronisers, counters and registered outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        led_d      = led_q;
        hexval_d   = hexval_q;
        hexblank_d = hexblank_q;
        edge_clr   = '0;
`ifdef PWM_EN
        bright_d   = bright_q;
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
`endif
        if (avs_write) begin
            case (addr)
                A_LED:      led_d      = avs_writedata[NUM_LEDS-1:0];
                A_HEXVAL:   hexval_d   = avs_writedata[4*NUM_HEX-1:0];
                A_HEXBLANK: hexblank_d = avs_writedata[NUM_HEX-1:0];
                A_KEYEDGE:  edge_clr   = avs_writedata[NUM_KEYS-1:0];
`ifdef PWM_EN
                A_RSVD:     bright_d   = avs_writedata[7:0];
`endif
                default: ;
            endcase
        end

        // A press arriving in the same cycle as its clear wins.
        keyedge_d  = (keyedge_q & ~edge_clr) | (keystat_d & ~keystat_q);

        sw_meta_d  = SW;
        sw_sync_d  = sw_meta_q;
        key_meta_d = KEY;
        key_sync_d = key_meta_q;
        count_d    = count_q + COUNT_W'(1);

        // Outputs follow the registers one cycle later; a gated-off PWM phase
        // turns LEDs off and drives every segment high (dark).
        ledr_d = led_q & {NUM_LEDS{pwm_on}};
        for (int i = 0; i < NUM_HEX; i++) begin
            hex_d[7*i +: 7] = (hexblank_q[i] ? 7'h7F : seg7(hexval_q[4*i +: 4]))
                              | {7{~pwm_on}};
        end
    end

    // Read mux samples the pre-write register values, so a simultaneous
    // read and write returns the old contents.
    always_comb begin
        readdata_d      = '0;
        readdatavalid_d = avs_read;
        if (avs_read) begin
            case (addr)
                A_LED:      readdata_d[NUM_LEDS-1:0]  = led_q;
                A_HEXVAL:   readdata_d[4*NUM_HEX-1:0] = hexval_q;
                A_HEXBLANK: readdata_d[NUM_HEX-1:0]   = hexblank_q;
                A_SWSTAT:   readdata_d[NUM_SW-1:0]    = sw_sync_q;
                A_KEYSTAT:  readdata_d[NUM_KEYS-1:0]  = keystat_q;
                A_KEYEDGE:  readdata_d[NUM_KEYS-1:0]  = keyedge_q;
                A_COUNT:    readdata_d[COUNT_W-1:0]   = count_q;
`ifdef PWM_EN
                A_RSVD:     readdata_d[7:0]           = bright_q;
`endif
                default: ;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            led_q           <= '0;
            hexval_q        <= '0;
            hexblank_q      <= '1;
            sw_meta_q       <= '0;
            sw_sync_q       <= '0;
            key_meta_q      <= '0;
            key_sync_q      <= '0;
            keystat_q       <= '0;
            keyedge_q       <= '0;
            count_q         <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            ledr_q          <= '0;
            hex_q           <= '1;
            // NOTE: the per-key arrays are control state, not data storage,
            // so each element is reset explicitly rather than left unknown.
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_state_q[k] <= ST_STABLE;
                deb_cnt_q[k]   <= '0;
            end
`ifdef PWM_EN
            bright_q        <= 8'hFF;
            pwm_cnt_q       <= '0;
`endif
        end else begin
            led_q           <= led_d;
            hexval_q        <= hexval_d;
            hexblank_q      <= hexblank_d;
            sw_meta_q       <= sw_meta_d;
            sw_sync_q       <= sw_sync_d;
            key_meta_q      <= key_meta_d;
            key_sync_q      <= key_sync_d;
            keystat_q       <= keystat_d;
            keyedge_q       <= keyedge_d;
            count_q         <= count_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            ledr_q          <= ledr_d;
            hex_q           <= hex_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_state_q[k] <= deb_state_d[k];
                deb_cnt_q[k]   <= deb_cnt_d[k];
            end
`ifdef PWM_EN
            bright_q        <= bright_d;
            pwm_cnt_q       <= pwm_cnt_d;
`endif
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign LEDR              = ledr_q;
    assign HEX               = hex_q;

endmodule

// File: tb/tb_board_io_hub.sv
// -----------------------------------------------------------------------------
// tb_board_io_hub
//
// Directed test of board_io_hub with a short debounce (4 cycles) and a 4-bit
// counter. Inputs are driven 1 time unit after each rising edge and outputs
// are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_board_io_hub;

    localparam int NUM_LEDS = 10;
    localparam int NUM_HEX  = 6;
    localparam int NUM_SW   = 10;
    localparam int NUM_KEYS = 4;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic [2:0]           avs_address;
    logic                 avs_read;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic [31:0]          avs_readdata;
    logic                 avs_readdatavalid;
    logic [NUM_LEDS-1:0]  LEDR;
    logic [7*NUM_HEX-1:0] HEX;
    logic [NUM_SW-1:0]    SW;
    logic [NUM_KEYS-1:0]  KEY;

    int n_cmp = 0;
    int n_bad = 0;

    // Cycles since the last reset edge; doubles as the expected COUNT and
    // PWM phase.
    logic [31:0] tb_cyc;

    board_io_hub #(
        .NUM_LEDS        (NUM_LEDS),
        .NUM_HEX         (NUM_HEX),
        .NUM_SW          (NUM_SW),
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (4),
        .COUNT_W         (4)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .LEDR              (LEDR),
        .HEX               (HEX),
        .SW                (SW),
        .KEY               (KEY)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (reset) tb_cyc <= 32'd0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Wait past the single gated-off PWM phase so static output checks hold.
    task automatic settle();
`ifdef PWM_EN
        if (tb_cyc[7:0] == 8'd0) step(1);
`endif
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step(1);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic [31:0] cyc);
        avs_address = a;
        avs_read    = 1'b1;
        cyc         = tb_cyc;
        step(1);
        avs_read    = 1'b0;
        d           = avs_readdata;
        chk("rd_valid", {63'd0, avs_readdatavalid}, 64'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [31:0] c;
        rd(a, d, c);
        chk(tag, {32'd0, d}, {32'd0, exp});
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] cv [17];
        logic [31:0] cc [17];
        int          hi;

        // ---------------- reset, with a read accepted during reset ----------
        reset = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = 3'd0;
        avs_writedata = '0; SW = '0; KEY = '1;
        step(1);
        chk("rst_read_no_valid", {63'd0, avs_readdatavalid}, 64'd0);
        avs_read = 1'b0;
        step(2);
        chk("rst_ledr", {54'd0, LEDR}, 64'd0);
        chk("rst_hex", {22'd0, HEX}, {22'd0, 42'h3FF_FFFF_FFFF});
        chk("rst_rdata", {32'd0, avs_readdata}, 64'd0);
        reset = 1'b0;

        rd_chk("rst_led",      3'd0, 32'h0);
        rd_chk("rst_hexval",   3'd1, 32'h0);
        rd_chk("rst_hexblank", 3'd2, 32'h3F);
        rd_chk("rst_swstat",   3'd3, 32'h0);
        rd_chk("rst_keystat",  3'd4, 32'h0);
        rd_chk("rst_keyedge",  3'd5, 32'h0);
        rd(3'd6, d, c);
        chk("rst_count", {32'd0, d}, {60'd0, c[3:0]});
        step(1);
        chk("valid_one_cycle", {63'd0, avs_readdatavalid}, 64'd0);

        // ---------------- HEX decode ----------------------------------------
        wr(3'd1, 32'h0000_F810);
        wr(3'd2, 32'h0000_0030);
        step(1); settle();
        chk("hex_0f810", {22'd0, HEX},
            {22'd0, 7'h7F, 7'h7F, 7'h0E, 7'h00, 7'h79, 7'h40});
        rd_chk("hexval_rb", 3'd1, 32'h0000_F810);
        wr(3'd1, 32'h00ED_CBA9);
        wr(3'd2, 32'h0);
        step(1); settle();
        chk("hex_edcba9", {22'd0, HEX},
            {22'd0, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10});
        wr(3'd1, 32'hFF76_5432);
        step(2); settle();
        chk("hex_765432", {22'd0, HEX},
            {22'd0, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24});
        rd_chk("hexval_trunc", 3'd1, 32'h0076_5432);

        // ---------------- LED, upper bits, read+write collision -------------
        wr(3'd0, 32'hFFFF_FFFF);
        rd_chk("led_trunc", 3'd0, 32'h3FF);
        settle();
        chk("ledr_on", {54'd0, LEDR}, 64'h3FF);
        avs_address = 3'd0; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 32'h155;
        step(1);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_old_value", {32'd0, avs_readdata}, 64'h3FF);
        rd_chk("rw_new_value", 3'd0, 32'h155);
        settle();
        chk("ledr_155", {54'd0, LEDR}, 64'h155);

        // ---------------- RO / reserved writes ignored -----------------------
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("swstat_ro", 3'd3, 32'h0);
        rd_chk("keystat_ro", 3'd4, 32'h0);
`ifndef PWM_EN
        wr(3'd7, 32'hFFFF_FFFF);
        rd_chk("rsvd_zero", 3'd7, 32'h0);
`endif

        // ---------------- switch synchroniser latency -----------------------
        SW = 10'h2A5;
        rd_chk("sw_lag1", 3'd3, 32'h0);
        rd_chk("sw_lag2", 3'd3, 32'h0);
        rd_chk("sw_new",  3'd3, 32'h2A5);

        // ---------------- 3-cycle glitch on KEY[2] is filtered --------------
        KEY = 4'b1011;
        step(3);
        KEY = 4'b1111;
        step(8);
        rd_chk("glitch_keystat", 3'd4, 32'h0);
        rd_chk("glitch_keyedge", 3'd5, 32'h0);

        // ---------------- clean press of KEY[2] -----------------------------
        KEY = 4'b1011;
        step(5);
        rd_chk("press_t5", 3'd4, 32'h0);
        rd_chk("press_t6", 3'd4, 32'h4);
        rd_chk("press_edge", 3'd5, 32'h4);
        step(3);
        KEY = 4'b1111;
        step(10);
        rd_chk("release_keystat", 3'd4, 32'h0);
        rd_chk("release_edge", 3'd5, 32'h4);

        // ---------------- W1C on the same cycle as a KEY[0] press ------------
        KEY = 4'b1110;
        step(5);
        wr(3'd5, 32'h4);
        rd_chk("w1c_with_edge", 3'd5, 32'h1);
        rd_chk("key0_keystat", 3'd4, 32'h1);
        KEY = 4'b1111;
        step(10);
        wr(3'd5, 32'h1);
        rd_chk("w1c_clear", 3'd5, 32'h0);

        // ---------------- set wins over clear on the same bit ----------------
        KEY = 4'b1101;
        step(5);
        wr(3'd5, 32'h3);
        rd_chk("set_wins", 3'd5, 32'h2);
        KEY = 4'b1111;
        step(10);
        rd_chk("key1_released", 3'd4, 32'h0);

        // ---------------- free-running counter wrap --------------------------
        for (int i = 0; i < 17; i++) rd(3'd6, cv[i], cc[i]);
        for (int i = 0; i < 17; i++)
            chk($sformatf("count_%0d", i), {32'd0, cv[i]}, {60'd0, cc[i][3:0]});
        chk("count_period16", {32'd0, cv[16]}, {32'd0, cv[0]});

`ifdef PWM_EN
        // ---------------- PWM brightness -------------------------------------
        wr(3'd0, 32'h3FF);
        wr(3'd7, 32'd64);
        rd_chk("bright_rb", 3'd7, 32'd64);
        step(2);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (LEDR[0]) hi++;
        end
        chk("pwm_64", hi, 64'd64);
        wr(3'd7, 32'd0);
        step(2);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (LEDR != '0) hi++;
        end
        chk("pwm_off", hi, 64'd0);
`endif

        // ---------------- reset mid-run --------------------------------------
        wr(3'd0, 32'h3FF);
        wr(3'd5, 32'hF);
        reset = 1'b1; avs_read = 1'b1; avs_address = 3'd0;
        step(1);
        chk("midrst_no_valid", {63'd0, avs_readdatavalid}, 64'd0);
        chk("midrst_rdata", {32'd0, avs_readdata}, 64'd0);
        chk("midrst_ledr", {54'd0, LEDR}, 64'd0);
        chk("midrst_hex", {22'd0, HEX}, {22'd0, 42'h3FF_FFFF_FFFF});
        avs_read = 1'b0;
        reset = 1'b0;
        rd_chk("midrst_led", 3'd0, 32'h0);
        rd_chk("midrst_hexval", 3'd1, 32'h0);
        rd_chk("midrst_hexblank", 3'd2, 32'h3F);
`ifdef PWM_EN
        rd_chk("midrst_bright", 3'd7, 32'hFF);
`else
        rd_chk("midrst_rsvd", 3'd7, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
